sig_key_sched: RTL and testbench

- Command sequencer between the 4x4 `keyboard` scanner and the m-sequence signal path (`signal_m`, clock-select mux, output select).
- Replaces the ad-hoc keytrig-edge logic with a single-clock FSM.
- Turns debounced key events into start/stop/restart sequencing of the generator, a 0..FREQ_MAX divider index and a sequence-select bit.
- Requests LCD refresh from `dis_state` through a req/ack handshake.

---
 rtl/sig_key_sched_if.sv | 42 ++++
 rtl/sig_key_sched.sv | 267 ++++++++++++++++++++++++++
 tb/tb_sig_key_sched.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sig_key_sched_if.sv
// -----------------------------------------------------------------------------
// sig_key_sched_if
// Bundles the key-scanner inputs, the generator/display control outputs and
// the display refresh handshake of sig_key_sched.
//   keytrig   : key-valid level from the scanner (asynchronous to clk)
//   keycode   : 4-bit scanner code, stable while keytrig is high
//   upd_ack   : one-cycle acknowledge from the display writer
//   freq_sel  : clock-select index for the clk_k mux
//   sig_sel   : 1 = modulated sequence, 0 = plain sequence
//   gen_rst   : active-high reset to the sequence generator
//   gen_en    : output enable to the sequence generator
//   running   : high while the generator runs
//   upd_req   : display refresh request
//   key_cnt   : count of accepted key events (wraps)
//   last_key  : last accepted keycode
// master = sequencer side, slave = scanner/generator/display side.
// -----------------------------------------------------------------------------
interface sig_key_sched_if;
    logic       keytrig;
    logic [3:0] keycode;
    logic       upd_ack;
    logic [3:0] freq_sel;
    logic       sig_sel;
    logic       gen_rst;
    logic       gen_en;
    logic       running;
    logic       upd_req;
    logic [3:0] key_cnt;
    logic [3:0] last_key;

    modport master (
        input  keytrig, keycode, upd_ack,
        output freq_sel, sig_sel, gen_rst, gen_en, running, upd_req,
               key_cnt, last_key
    );

    modport slave (
        output keytrig, keycode, upd_ack,
        input  freq_sel, sig_sel, gen_rst, gen_en, running, upd_req,
               key_cnt, last_key
    );
endinterface

// File: rtl/sig_key_sched.sv
// -----------------------------------------------------------------------------
// sig_key_sched
// Command sequencer between the 4x4 key scanner and the m-sequence signal
// path. Debounced key events drive start/stop/restart of the generator, a
// 0..FREQ_MAX clock-select index and the sequence-select bit; any visible
// change raises a display refresh request held until acknowledged.
// Ports:
//   clk    : system clock
//   areset : asynchronous active-high reset
//   bus    : sig_key_sched_if.master (key inputs, control outputs, handshake)
// -----------------------------------------------------------------------------
module sig_key_sched #(
    parameter int FREQ_MAX    = 9,
    parameter int FREQ_INIT   = 5,
    parameter int RST_CYC     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             areset,
    sig_key_sched_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESTART = 2'd1,
        ST_RUN     = 2'd2,
        ST_STOP    = 2'd3
    } state_t;

    localparam int              CNT_W        = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] LP_CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]      LP_FREQ_MAX  = 4'(FREQ_MAX);
    localparam logic [3:0]      LP_FREQ_INIT = 4'(FREQ_INIT);

    localparam logic [3:0] KEY_START  = 4'b0010;
    localparam logic [3:0] KEY_STOP   = 4'b0100;
    localparam logic [3:0] KEY_TOGGLE = 4'b0001;
    localparam logic [3:0] KEY_UP     = 4'b1100;
    localparam logic [3:0] KEY_DOWN   = 4'b1000;

    // UP wraps from the top index back to 0.
    function automatic logic [3:0] f_freq_up(input logic [3:0] f);
        f_freq_up = (f >= LP_FREQ_MAX) ? 4'd0 : f + 4'd1;
    endfunction

    // DOWN wraps from 0 to the top index.
    function automatic logic [3:0] f_freq_down(input logic [3:0] f);
        f_freq_down = (f == 4'd0) ? LP_FREQ_MAX : f - 4'd1;
    endfunction

    // Scanner code to digit: {is_digit, value}.
    function automatic logic [4:0] f_digit(input logic [3:0] code);
        case (code)
            4'b0011: f_digit = {1'b1, 4'd0};
            4'b0111: f_digit = {1'b1, 4'd1};
            4'b0110: f_digit = {1'b1, 4'd2};
            4'b0101: f_digit = {1'b1, 4'd3};
            4'b1011: f_digit = {1'b1, 4'd4};
            4'b1010: f_digit = {1'b1, 4'd5};
            4'b1001: f_digit = {1'b1, 4'd6};
            4'b1111: f_digit = {1'b1, 4'd7};
            4'b1110: f_digit = {1'b1, 4'd8};
            4'b1101: f_digit = {1'b1, 4'd9};
            default: f_digit = {1'b0, 4'd0};
        endcase
    endfunction

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_trig_d;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [3:0]             r_freq;
    logic                   r_sig;
    logic                   r_gen_rst;
    logic                   r_gen_en;
    logic                   r_running;
    logic                   r_upd_req;
    logic [3:0]             r_key_cnt;
    logic [3:0]             r_last_key;

    logic             w_event;
    logic [4:0]       w_digit;
    logic             w_k_start;
    logic             w_k_stop;
    logic             w_k_toggle;
    logic             w_k_up;
    logic             w_k_down;
    logic             w_k_digit;
    logic             w_freq_req;
    logic [3:0]       w_freq_val;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_freq_nxt;
    logic             w_sig_nxt;
    logic             w_change;

    // One event per keytrig high period: rising edge after synchronisation.
    assign w_event    = r_sync[SYNC_STAGES-1] & ~r_trig_d;
    assign w_digit    = f_digit(bus.keycode);
    assign w_k_start  = w_event & (bus.keycode == KEY_START);
    assign w_k_stop   = w_event & (bus.keycode == KEY_STOP);
    assign w_k_toggle = w_event & (bus.keycode == KEY_TOGGLE);
    assign w_k_up     = w_event & (bus.keycode == KEY_UP);
    assign w_k_down   = w_event & (bus.keycode == KEY_DOWN);
    // Out-of-range digits are dropped here so they never touch the index.
    assign w_k_digit  = w_event & w_digit[4] & (w_digit[3:0] <= LP_FREQ_MAX);

    // Requested new index from UP/DOWN/digit; a digit equal to the current
    // index is not a change and therefore causes no restart.
    always_comb begin
        w_freq_req = 1'b0;
        w_freq_val = r_freq;
        if (w_k_up) begin
            w_freq_req = 1'b1;
            w_freq_val = f_freq_up(r_freq);
        end else if (w_k_down) begin
            w_freq_req = 1'b1;
            w_freq_val = f_freq_down(r_freq);
        end else if (w_k_digit && (w_digit[3:0] != r_freq)) begin
            w_freq_req = 1'b1;
            w_freq_val = w_digit[3:0];
        end else begin
            w_freq_req = 1'b0;
            w_freq_val = r_freq;
        end
    end

    // Next-state, restart counter, index and sequence-select decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_freq_nxt  = r_freq;
        w_sig_nxt   = w_k_toggle ? ~r_sig : r_sig;
        case (r_state)
            ST_IDLE: begin
                if (w_k_start) begin
                    w_freq_nxt  = LP_FREQ_INIT;
                    w_state_nxt = ST_RESTART;
                    w_cnt_nxt   = LP_CNT_ZERO;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RESTART: begin
                if (w_k_stop) begin
                    w_state_nxt = ST_STOP;
                end else if (w_k_start) begin
                    w_freq_nxt = LP_FREQ_INIT;
                    w_cnt_nxt  = LP_CNT_ZERO;
                end else if (w_freq_req) begin
                    // New clock while resetting: hold reset a full period again.
                    w_freq_nxt = w_freq_val;
                    w_cnt_nxt  = LP_CNT_ZERO;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = LP_CNT_ZERO;
                end else begin
                    w_cnt_nxt = r_cnt + LP_CNT_ONE;
                end
            end
            ST_RUN: begin
                if (w_k_stop) begin
                    w_state_nxt = ST_STOP;
                end else if (w_k_start) begin
                    w_freq_nxt  = LP_FREQ_INIT;
                    w_state_nxt = ST_RESTART;
                    w_cnt_nxt   = LP_CNT_ZERO;
                end else if (w_freq_req) begin
                    // Re-seed the generator on the new clock.
                    w_freq_nxt  = w_freq_val;
                    w_state_nxt = ST_RESTART;
                    w_cnt_nxt   = LP_CNT_ZERO;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_STOP: begin
                if (w_k_start) begin
                    // Resume at the held index.
                    w_state_nxt = ST_RESTART;
                    w_cnt_nxt   = LP_CNT_ZERO;
                end else begin
                    w_state_nxt = ST_STOP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = LP_CNT_ZERO;
                w_freq_nxt  = LP_FREQ_INIT;
            end
        endcase
    end

    assign w_change = (w_state_nxt != r_state) | (w_freq_nxt != r_freq) |
                      (w_sig_nxt != r_sig);

    // keytrig synchroniser and edge-detect history.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_sync   <= '0;
            r_trig_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], bus.keytrig};
            r_trig_d <= r_sync[SYNC_STAGES-1];
        end
    end

    // FSM state, restart counter and registered control outputs.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= LP_CNT_ZERO;
            r_freq    <= LP_FREQ_INIT;
            r_sig     <= 1'b0;
            r_gen_rst <= 1'b1;
            r_gen_en  <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_freq    <= w_freq_nxt;
            r_sig     <= w_sig_nxt;
            r_gen_rst <= (w_state_nxt != ST_RUN);
            r_gen_en  <= (w_state_nxt == ST_RUN);
            r_running <= (w_state_nxt == ST_RUN);
        end
    end

    // Display request: a new change wins over a same-cycle acknowledge.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_upd_req <= 1'b0;
        end else if (w_change) begin
            r_upd_req <= 1'b1;
        end else if (bus.upd_ack) begin
            r_upd_req <= 1'b0;
        end else begin
            r_upd_req <= r_upd_req;
        end
    end

    // Key event bookkeeping.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_key_cnt  <= 4'd0;
            r_last_key <= 4'd0;
        end else if (w_event) begin
            r_key_cnt  <= r_key_cnt + 4'd1;
            r_last_key <= bus.keycode;
        end else begin
            r_key_cnt  <= r_key_cnt;
            r_last_key <= r_last_key;
        end
    end

    assign bus.freq_sel = r_freq;
    assign bus.sig_sel  = r_sig;
    assign bus.gen_rst  = r_gen_rst;
    assign bus.gen_en   = r_gen_en;
    assign bus.running  = r_running;
    assign bus.upd_req  = r_upd_req;
    assign bus.key_cnt  = r_key_cnt;
    assign bus.last_key = r_last_key;

endmodule

// File: tb/tb_sig_key_sched.sv
// -----------------------------------------------------------------------------
// tb_sig_key_sched
// Directed bench for sig_key_sched: reset values, START sequencing, a table of
// key events in RUN/STOP, the acknowledge race and reset during RESTART. A
// second instance with FREQ_MAX=7 sees the same key stream.
// -----------------------------------------------------------------------------
module tb_sig_key_sched;

    logic       clk = 1'b0;
    logic       areset;
    logic       tb_trig;
    logic [3:0] tb_code;
    logic       tb_ack;

    int n_tests = 0;
    int n_fail  = 0;

    sig_key_sched_if u_if ();
    sig_key_sched_if u_if7 ();

    assign u_if.keytrig  = tb_trig;
    assign u_if.keycode  = tb_code;
    assign u_if.upd_ack  = tb_ack;
    assign u_if7.keytrig = tb_trig;
    assign u_if7.keycode = tb_code;
    assign u_if7.upd_ack = tb_ack;

    sig_key_sched #(
        .FREQ_MAX(9), .FREQ_INIT(5), .RST_CYC(4), .SYNC_STAGES(2)
    ) u_dut (
        .clk    (clk),
        .areset (areset),
        .bus    (u_if.master)
    );

    sig_key_sched #(
        .FREQ_MAX(7), .FREQ_INIT(5), .RST_CYC(4), .SYNC_STAGES(2)
    ) u_dut7 (
        .clk    (clk),
        .areset (areset),
        .bus    (u_if7.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] code;
        int         hold;
        logic [3:0] freq;
        logic       sig;
        logic [3:0] cnt;
        int         rst;
        logic       run;
        logic [3:0] freq7;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    // Press a key for 'hold' cycles, release, settle; count gen_rst samples.
    task automatic press(input logic [3:0] code, input int hold, output int rc);
        rc = 0;
        tb_code = code;
        tb_trig = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (u_if.gen_rst) rc++;
        end
        tb_trig = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (u_if.gen_rst) rc++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;

        //            code     hold  freq sig  cnt   rst run freq7
        vecs[0]  = '{4'b1101,    3, 4'd9, 1'b0, 4'd2,  4, 1'b1, 4'd5};
        vecs[1]  = '{4'b0010,    3, 4'd5, 1'b0, 4'd3,  4, 1'b1, 4'd5};
        vecs[2]  = '{4'b1100,    3, 4'd6, 1'b0, 4'd4,  4, 1'b1, 4'd6};
        vecs[3]  = '{4'b1100,    3, 4'd7, 1'b0, 4'd5,  4, 1'b1, 4'd7};
        vecs[4]  = '{4'b1100,    3, 4'd8, 1'b0, 4'd6,  4, 1'b1, 4'd0};
        vecs[5]  = '{4'b1100,    3, 4'd9, 1'b0, 4'd7,  4, 1'b1, 4'd1};
        vecs[6]  = '{4'b1100,    3, 4'd0, 1'b0, 4'd8,  4, 1'b1, 4'd2};
        vecs[7]  = '{4'b1000,    3, 4'd9, 1'b0, 4'd9,  4, 1'b1, 4'd1};
        vecs[8]  = '{4'b0101,    3, 4'd3, 1'b0, 4'd10, 4, 1'b1, 4'd3};
        vecs[9]  = '{4'b0101,    3, 4'd3, 1'b0, 4'd11, 0, 1'b1, 4'd3};
        vecs[10] = '{4'b0100,    3, 4'd3, 1'b0, 4'd12, 13, 1'b0, 4'd3};
        vecs[11] = '{4'b1100,    3, 4'd3, 1'b0, 4'd13, 15, 1'b0, 4'd3};
        vecs[12] = '{4'b0111,    3, 4'd3, 1'b0, 4'd14, 15, 1'b0, 4'd3};
        vecs[13] = '{4'b0010,    3, 4'd3, 1'b0, 4'd15, 6, 1'b1, 4'd3};
        vecs[14] = '{4'b0000,    3, 4'd3, 1'b0, 4'd0,  0, 1'b1, 4'd3};
        vecs[15] = '{4'b0001, 1000, 4'd3, 1'b1, 4'd1,  0, 1'b1, 4'd3};

        areset  = 1'b1;
        tb_trig = 1'b0;
        tb_code = 4'd0;
        tb_ack  = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_freq",    0, 32'(u_if.freq_sel), 32'd5);
        check("rst_sig",     0, 32'(u_if.sig_sel),  32'd0);
        check("rst_gen_rst", 0, 32'(u_if.gen_rst),  32'd1);
        check("rst_gen_en",  0, 32'(u_if.gen_en),   32'd0);
        check("rst_running", 0, 32'(u_if.running),  32'd0);
        check("rst_upd_req", 0, 32'(u_if.upd_req),  32'd0);
        check("rst_key_cnt", 0, 32'(u_if.key_cnt),  32'd0);
        check("rst_last_key",0, 32'(u_if.last_key), 32'd0);

        areset = 1'b0;
        repeat (2) @(negedge clk);

        // START from IDLE, keytrig held 20 cycles.
        tb_code = 4'b0010;
        tb_trig = 1'b1;
        repeat (2) @(negedge clk);
        check("start_pre_cnt", 0, 32'(u_if.key_cnt), 32'd0);
        @(negedge clk);
        check("start_cnt",     0, 32'(u_if.key_cnt),  32'd1);
        check("start_freq",    0, 32'(u_if.freq_sel), 32'd5);
        check("start_running", 0, 32'(u_if.running),  32'd0);
        check("start_upd_req", 0, 32'(u_if.upd_req),  32'd1);
        rc = 0;
        for (int i = 0; i < 50; i++) begin
            if (!u_if.gen_rst) break;
            rc++;
            @(negedge clk);
        end
        check("start_rst_len", 0, rc, 32'd4);
        check("start_gen_en",  0, 32'(u_if.gen_en),  32'd1);
        check("start_running", 1, 32'(u_if.running), 32'd1);
        repeat (13) @(negedge clk);
        tb_trig = 1'b0;
        repeat (6) @(negedge clk);
        check("start_cnt_held",  0, 32'(u_if.key_cnt),  32'd1);
        check("start_req_held",  0, 32'(u_if.upd_req),  32'd1);
        check("start7_freq",     0, 32'(u_if7.freq_sel), 32'd5);
        check("start7_running",  0, 32'(u_if7.running),  32'd1);
        tb_ack = 1'b1;
        @(negedge clk);
        tb_ack = 1'b0;
        check("ack_clears", 0, 32'(u_if.upd_req), 32'd0);

        // Key table.
        for (int v = 0; v < 16; v++) begin
            press(vecs[v].code, vecs[v].hold, rc);
            check("vec_freq",     v, 32'(u_if.freq_sel),  32'(vecs[v].freq));
            check("vec_sig",      v, 32'(u_if.sig_sel),   32'(vecs[v].sig));
            check("vec_key_cnt",  v, 32'(u_if.key_cnt),   32'(vecs[v].cnt));
            check("vec_last_key", v, 32'(u_if.last_key),  32'(vecs[v].code));
            check("vec_rst_cyc",  v, rc,                  vecs[v].rst);
            check("vec_running",  v, 32'(u_if.running),   32'(vecs[v].run));
            check("vec_gen_en",   v, 32'(u_if.gen_en),    32'(vecs[v].run));
            check("vec7_freq",    v, 32'(u_if7.freq_sel), 32'(vecs[v].freq7));
            check("vec7_running", v, 32'(u_if7.running),  32'(vecs[v].run));
            check("vec7_sig",     v, 32'(u_if7.sig_sel),  32'(vecs[v].sig));
        end

        // Acknowledge in the same cycle a TOGGLE takes effect (request pending).
        check("race_pre_req", 0, 32'(u_if.upd_req), 32'd1);
        tb_code = 4'b0001;
        tb_trig = 1'b1;
        repeat (2) @(negedge clk);
        tb_ack = 1'b1;
        @(negedge clk);
        tb_ack = 1'b0;
        check("race_sig",     0, 32'(u_if.sig_sel), 32'd0);
        check("race_req",     0, 32'(u_if.upd_req), 32'd1);
        check("race_key_cnt", 0, 32'(u_if.key_cnt), 32'd2);
        tb_ack = 1'b1;
        @(negedge clk);
        tb_ack = 1'b0;
        check("race_ack2", 0, 32'(u_if.upd_req), 32'd0);
        tb_trig = 1'b0;
        repeat (6) @(negedge clk);
        tb_ack = 1'b1;
        @(negedge clk);
        tb_ack = 1'b0;
        check("idle_ack_req", 0, 32'(u_if.upd_req), 32'd0);
        check("idle_ack_run", 0, 32'(u_if.running), 32'd1);

        // areset while in RESTART after UP (3 -> 4).
        tb_code = 4'b1100;
        tb_trig = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_freq",    0, 32'(u_if.freq_sel), 32'd4);
        check("mid_gen_rst", 0, 32'(u_if.gen_rst),  32'd1);
        check("mid_req",     0, 32'(u_if.upd_req),  32'd1);
        areset = 1'b1;
        #1;
        check("ar_freq",     0, 32'(u_if.freq_sel), 32'd5);
        check("ar_sig",      0, 32'(u_if.sig_sel),  32'd0);
        check("ar_gen_rst",  0, 32'(u_if.gen_rst),  32'd1);
        check("ar_gen_en",   0, 32'(u_if.gen_en),   32'd0);
        check("ar_running",  0, 32'(u_if.running),  32'd0);
        check("ar_upd_req",  0, 32'(u_if.upd_req),  32'd0);
        check("ar_key_cnt",  0, 32'(u_if.key_cnt),  32'd0);
        check("ar_last_key", 0, 32'(u_if.last_key), 32'd0);
        tb_trig = 1'b0;
        repeat (3) @(negedge clk);
        areset = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_freq", 0, 32'(u_if.freq_sel), 32'd5);
        check("post_rst_run",  0, 32'(u_if.running),  32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
